// File: rtl/accu_tx_pkg.sv
// rtl/accu_tx_pkg.sv - shared types and constants for the accumulator serial output port
package accu_tx_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/accu_tx_port_if.sv
// rtl/accu_tx_port_if.sv - write strobe, status flags and serial line of the output port
interface accu_tx_port_if;
    import accu_tx_pkg::*;

    logic              WrEn;
    logic [DATA_W-1:0] WrData;
    logic              Full;
    logic              Empty;
    logic              Busy;
    logic              Overflow;
    logic              TxD;

    modport master (
        output WrEn, WrData,
        input  Full, Empty, Busy, Overflow, TxD
    );

    modport slave (
        input  WrEn, WrData,
        output Full, Empty, Busy, Overflow, TxD
    );
endinterface

// File: rtl/accu_tx_fifo.sv
// rtl/accu_tx_fifo.sv - synchronous byte FIFO with registered occupancy count
module accu_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from the registered count, so a push is judged on pre-edge fullness.
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/accu_tx_port.sv
// rtl/accu_tx_port.sv - queues accumulator writes and sends them 8N1, LSB first
module accu_tx_port
    import accu_tx_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 Reset,
    accu_tx_port_if.slave        bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_t         state, state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_n;
    logic [BIT_W-1:0]  bit_cnt, bit_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              txd_q, txd_n;
    logic              busy_q;
    logic              overflow_q;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] pop_data;
    logic              baud_last;

    accu_tx_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (Reset),
        .push      (bus.WrEn),
        .push_data (bus.WrData),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign baud_last    = (baud_cnt == BAUD_LAST);
    assign bus.Full     = fifo_full;
    assign bus.Empty    = fifo_empty;
    assign bus.Busy     = busy_q;
    assign bus.Overflow = overflow_q;
    assign bus.TxD      = txd_q;

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        txd_n   = txd_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = pop_data;
                    txd_n   = 1'b0;
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_last) begin
                    txd_n   = shift[0];
                    bit_n   = '0;
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_cnt == BIT_LAST) begin
                        txd_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        // shift[1] is the bit that lands in shift[0] after this shift.
                        shift_n = shift >> 1;
                        bit_n   = bit_cnt + BIT_W'(1);
                        txd_n   = shift[1];
                    end
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shift      <= shift_n;
            txd_q      <= txd_n;
            busy_q     <= (state_n != IDLE);
            overflow_q <= overflow_q | (bus.WrEn & fifo_full);
        end
    end
endmodule

// File: doc/accu_tx_port.md
Name: accu_tx_port

Overview:
- Output stage downstream of the accumulator in the 8-bit core.
- When the instruction decoder issues a port-write strobe, the current accumulator value is captured into a small FIFO.
- Queued bytes are serialised on one UART-style line, 8N1, LSB first.
- The core never stalls; it can poll Full to avoid losing bytes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CLKS_PER_BIT, 16, clk cycles per serial bit; at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- WrEn  in  1  port-write strobe from the instruction decoder; one byte per cycle asserted.
- WrData  in  8  accumulator value to enqueue.
- Full  out  1  FIFO holds DEPTH entries (registered count == DEPTH).
- Empty  out  1  FIFO holds 0 entries.
- Busy  out  1  transmitter FSM is not in IDLE.
- Overflow  out  1  sticky: a write was dropped.
- TxD  out  1  serial line; idles high.

Behaviour:
- Reset (synchronous, active-high): applies on the clk edge while Reset=1 and overrides every other event.
  - FIFO count, read pointer and write pointer go to 0.
  - State goes to IDLE; baud and bit counters go to 0.
  - TxD=1, Busy=0, Full=0, Empty=1, Overflow=0.
  - Reset mid-frame aborts the frame, returns TxD high at the next edge and discards queued data.
- Push:
  - On an edge with WrEn=1 and Full=0, WrData is written at the write pointer; the write pointer increments modulo DEPTH.
  - If WrEn=1 and Full=1, nothing is written and Overflow is set to 1. Overflow clears only on Reset.
  - Full and Empty are sampled before the edge. A push in the same cycle as a pop while Full=1 is still rejected.
- Pop: occurs only from IDLE when Empty=0. The head entry loads the 8-bit shift register and the read pointer increments modulo DEPTH.
- Count update:
  - Simultaneous accepted push and pop: count unchanged.
  - Accepted push only: count +1.
  - Pop only: count -1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TxD=1. If Empty=0: pop, TxD<=0, go to START, baud counter=0.
  - START: hold TxD=0 for CLKS_PER_BIT cycles. Then TxD<=shift[0], bit counter=0, go to DATA.
  - DATA: each bit is held for CLKS_PER_BIT cycles. Then shift right, bit counter +1, TxD<=next bit. After bit 7 completes, TxD<=1 and go to STOP.
  - STOP: hold TxD=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - One frame is 10*CLKS_PER_BIT cycles, plus 1 IDLE cycle between back-to-back frames.
- Busy = (state != IDLE), registered.
- Latency: a WrEn at edge E into an empty FIFO with an idle FSM gives Empty=0 after E. The pop happens at edge E+1 and TxD falls after E+1.
- TxD is a registered output with no glitches.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits.
  - Bit counter: 3 bits.
  - Count: $clog2(DEPTH)+1 bits.
  - Pointers wrap naturally.

Decomposition:
- Package accu_tx_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - DATA_W=8;
  - FRAME_BITS=10.
- Sub-module accu_tx_fifo holds the synchronous FIFO (push/pop, count, Full/Empty, same reset rules).
- The top level contains the FSM, the shift register, the counters and the Overflow flag.

Test Plan (CLKS_PER_BIT=4, DEPTH=4):
- Reset then idle 20 cycles -> TxD=1, Busy=0, Empty=1, Full=0, Overflow=0 throughout.
- Single WrEn with 0xA5 -> TxD falls one cycle after Empty drops. The line then carries 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles. Busy is high for 40 cycles, then Empty=1.
- Six consecutive WrEn with 0x01..0x06 while idle:
  - First pop after the 0x01 write.
  - 0x02..0x05 are queued and Full=1 after the fifth write.
  - 0x06 is dropped and Overflow=1.
  - Frames 0x01..0x05 go out back-to-back with one idle cycle between them; 0x06 never appears.
- WrEn on the same cycle the FSM pops, with 1 entry queued -> count unchanged, no data lost. Bytes are transmitted in write order.
- Reset asserted during DATA bit 3 of 0x3C with 2 entries queued -> next edge TxD=1, IDLE, Empty=1. No further frames.
- WrEn held while Reset=1 -> no entry enqueued, Overflow stays 0.
